camera_trigger_generator: RTL and testbench

Converts the single-cycle `trigger_frame` strobe produced by the IMU synchroniser into a programmable-delay, programmable-width camera exposure trigger, and emits a per-frame event (frame id) to the downstream timestamp/metadata logic through a valid/ready handshake. Sits directly downstream of `imu_synchroniser` in the 200 MHz sensor-sync clock domain. Its output pin drives the image sensors' external trigger inputs.

---
 rtl/camera_trigger_generator.sv | 159 +++++++++++++++
 tb/tb_camera_trigger_generator.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_trigger_generator.sv
// Turns a one-cycle frame strobe into a delayed, width-programmable camera
// exposure trigger and publishes the frame id of each trigger over valid/ready.
module camera_trigger_generator #(
  parameter int CNT_W = 24,
  parameter int ID_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger_in,
  input  logic             enable,
  input  logic [CNT_W-1:0] delay_cycles,
  input  logic [CNT_W-1:0] pulse_cycles,
  output logic             cam_trigger,
  output logic             busy,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [ID_W-1:0]  frame_id,
  output logic             overrun,
  output logic [15:0]      overrun_count,
  output logic             event_lost,
  output logic [1:0]       dbg_state_o
);

  // Handshake: an event transfers on any clk edge where frame_valid && frame_ready;
  // frame_valid is held with a stable frame_id until then, except that a newer
  // trigger replaces an unaccepted event and flags event_lost.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_PULSE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             cam_q, cam_d;
  logic             rise;
  logic [CNT_W-1:0] pulse_eff;

  logic [ID_W-1:0]  id_cnt_q, id_cnt_d;
  logic [ID_W-1:0]  frame_id_q, frame_id_d;
  logic             valid_q, valid_d;
  logic             lost_q, lost_d;
  logic             ov_q, ov_d;
  logic [15:0]      ov_cnt_q, ov_cnt_d;
  logic             drop_busy;

  assign pulse_eff = (pulse_cycles == '0) ? CNT_ONE : pulse_cycles;

  // The counter holds "cycles remaining minus one" so terminal count is zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    cam_d   = cam_q;
    rise    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger_in && enable) begin
          width_d = pulse_eff;
          if (delay_cycles == '0) begin
            state_d = S_PULSE;
            cnt_d   = pulse_eff - CNT_ONE;
            cam_d   = 1'b1;
            rise    = 1'b1;
          end else begin
            state_d = S_DELAY;
            cnt_d   = delay_cycles - CNT_ONE;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = width_q - CNT_ONE;
          cam_d   = 1'b1;
          rise    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cam_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cam_d   = 1'b0;
      end
    endcase
  end

  // Only triggers arriving while a trigger is in flight count as overruns;
  // a disabled idle block drops triggers silently.
  assign drop_busy = trigger_in && (state_q != S_IDLE);

  always_comb begin
    id_cnt_d   = id_cnt_q;
    frame_id_d = frame_id_q;
    valid_d    = valid_q;
    lost_d     = 1'b0;
    ov_d       = drop_busy;
    ov_cnt_d   = ov_cnt_q;
    if (rise) begin
      id_cnt_d   = id_cnt_q + 1'b1;
      frame_id_d = id_cnt_q;
      valid_d    = 1'b1;
      lost_d     = valid_q && !frame_ready;
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end
    if (drop_busy && (ov_cnt_q != 16'hFFFF)) begin
      ov_cnt_d = ov_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      width_q    <= '0;
      cam_q      <= 1'b0;
      id_cnt_q   <= '0;
      frame_id_q <= '0;
      valid_q    <= 1'b0;
      lost_q     <= 1'b0;
      ov_q       <= 1'b0;
      ov_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      width_q    <= width_d;
      cam_q      <= cam_d;
      id_cnt_q   <= id_cnt_d;
      frame_id_q <= frame_id_d;
      valid_q    <= valid_d;
      lost_q     <= lost_d;
      ov_q       <= ov_d;
      ov_cnt_q   <= ov_cnt_d;
    end
  end

  assign cam_trigger   = cam_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_valid   = valid_q;
  assign frame_id      = frame_id_q;
  assign overrun       = ov_q;
  assign overrun_count = ov_cnt_q;
  assign event_lost    = lost_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_camera_trigger_generator.sv
// Directed bench for camera_trigger_generator: a table of delay/pulse configs
// plus hand-written sequences for overrun, backpressure, enable and reset.
module tb_camera_trigger_generator;

  logic        clk;
  logic        rst_n;
  logic        trigger_in;
  logic        enable;
  logic [23:0] delay_cycles;
  logic [23:0] pulse_cycles;
  logic        cam_trigger;
  logic        busy;
  logic        frame_valid;
  logic        frame_ready;
  logic [31:0] frame_id;
  logic        overrun;
  logic [15:0] overrun_count;
  logic        event_lost;
  logic [1:0]  dbg_state;

  camera_trigger_generator #(.CNT_W(24), .ID_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .trigger_in    (trigger_in),
    .enable        (enable),
    .delay_cycles  (delay_cycles),
    .pulse_cycles  (pulse_cycles),
    .cam_trigger   (cam_trigger),
    .busy          (busy),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .frame_id      (frame_id),
    .overrun       (overrun),
    .overrun_count (overrun_count),
    .event_lost    (event_lost),
    .dbg_state_o   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;
  int rise_total = 0;
  int lost_total = 0;
  logic cam_prev = 1'b0;

  // edge monitors, sampled mid-cycle
  always @(negedge clk) begin
    if (cam_trigger && !cam_prev) rise_total++;
    if (event_lost) lost_total++;
    cam_prev = cam_trigger;
  end

  typedef struct {
    logic [23:0] d;
    logic [23:0] p;
    int          exp_rise;
    int          exp_width;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      if (!busy) break;
      step();
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  // One accepted trigger; measures rise offset (k=0 is the cycle after the
  // trigger cycle) and high width. Optional mid-run enable drop / pulse change.
  task automatic fire(input logic [23:0] d, input logic [23:0] p,
                      input int drop_en_at, input int chg_at, input logic [23:0] chg_val,
                      output int rise_k, output int width,
                      output logic [31:0] id_r, output logic v_r, output logic b0);
    delay_cycles = d;
    pulse_cycles = p;
    trigger_in   = 1'b1;
    step();
    trigger_in   = 1'b0;
    rise_k = -1;
    width  = 0;
    id_r   = '0;
    v_r    = 1'b0;
    b0     = busy;
    for (int k = 0; k < 3000; k++) begin
      if (k == drop_en_at) enable = 1'b0;
      if (k == chg_at) pulse_cycles = chg_val;
      if (cam_trigger) begin
        if (rise_k < 0) begin
          rise_k = k;
          id_r   = frame_id;
          v_r    = frame_valid;
        end
        width++;
      end else if (rise_k >= 0) begin
        break;
      end
      step();
    end
  endtask

  int          rk, wd;
  logic [31:0] idr;
  logic        vr, b0;
  int          exp_id;
  int          r0, l0;
  logic [15:0] ov0;

  initial begin
    vecs[0] = '{d: 24'd10, p: 24'd200, exp_rise: 10, exp_width: 200};
    vecs[1] = '{d: 24'd0,  p: 24'd0,   exp_rise: 0,  exp_width: 1};
    vecs[2] = '{d: 24'd0,  p: 24'd1,   exp_rise: 0,  exp_width: 1};
    vecs[3] = '{d: 24'd1,  p: 24'd0,   exp_rise: 1,  exp_width: 1};
    vecs[4] = '{d: 24'd3,  p: 24'd5,   exp_rise: 3,  exp_width: 5};
    vecs[5] = '{d: 24'd2,  p: 24'd2,   exp_rise: 2,  exp_width: 2};

    rst_n        = 1'b0;
    trigger_in   = 1'b0;
    enable       = 1'b0;
    delay_cycles = '0;
    pulse_cycles = '0;
    frame_ready  = 1'b1;
    exp_id       = 0;
    repeat (3) step();

    // reset state
    check("rst_cam", {31'd0, cam_trigger}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_lost", {31'd0, event_lost}, 32'd0);
    check("rst_id", frame_id, 32'd0);
    check("rst_ovcnt", {16'd0, overrun_count}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    step();

    // table-driven trigger timing
    for (int i = 0; i < 6; i++) begin
      fire(vecs[i].d, vecs[i].p, -1, -1, 24'd0, rk, wd, idr, vr, b0);
      check($sformatf("v%0d_busy_t1", i), {31'd0, b0}, 32'd1);
      check($sformatf("v%0d_rise", i), rk, vecs[i].exp_rise);
      check($sformatf("v%0d_width", i), wd, vecs[i].exp_width);
      check($sformatf("v%0d_valid", i), {31'd0, vr}, 32'd1);
      check($sformatf("v%0d_id", i), idr, exp_id);
      check($sformatf("v%0d_busy_end", i), {31'd0, busy}, 32'd0);
      exp_id++;
      step();
    end

    // overrun: second trigger 50 cycles into a long pulse
    r0 = rise_total;
    ov0 = overrun_count;
    delay_cycles = 24'd10;
    pulse_cycles = 24'd200;
    trigger_in = 1'b1;
    step();
    trigger_in = 1'b0;
    repeat (49) step();
    trigger_in = 1'b1;
    step();
    trigger_in = 1'b0;
    check("ov_pulse", {31'd0, overrun}, 32'd1);
    check("ov_count", {16'd0, overrun_count}, {16'd0, ov0 + 16'd1});
    step();
    check("ov_pulse_clear", {31'd0, overrun}, 32'd0);
    wait_idle();
    step();
    check("ov_one_rise", rise_total - r0, 32'd1);
    exp_id++;

    // back-to-back: trigger on the last PULSE cycle is dropped, next cycle accepted
    ov0 = overrun_count;
    delay_cycles = 24'd0;
    pulse_cycles = 24'd3;
    trigger_in = 1'b1;
    step();
    trigger_in = 1'b0;
    step();
    step();
    trigger_in = 1'b1;
    step();
    check("b2b_overrun", {31'd0, overrun}, 32'd1);
    check("b2b_cam_low", {31'd0, cam_trigger}, 32'd0);
    check("b2b_busy_low", {31'd0, busy}, 32'd0);
    step();
    trigger_in = 1'b0;
    check("b2b_accept_busy", {31'd0, busy}, 32'd1);
    check("b2b_accept_cam", {31'd0, cam_trigger}, 32'd1);
    check("b2b_ovcnt", {16'd0, overrun_count}, {16'd0, ov0 + 16'd1});
    exp_id += 2;
    wait_idle();
    step();

    // enable dropped mid-pulse: full width, then later trigger ignored silently
    fire(24'd2, 24'd20, 5, -1, 24'd0, rk, wd, idr, vr, b0);
    check("en_rise", rk, 32'd2);
    check("en_width", wd, 32'd20);
    check("en_id", idr, exp_id);
    exp_id++;
    step();
    ov0 = overrun_count;
    trigger_in = 1'b1;
    step();
    trigger_in = 1'b0;
    check("en_ignored_busy", {31'd0, busy}, 32'd0);
    check("en_ignored_ov", {31'd0, overrun}, 32'd0);
    step();
    check("en_ignored_ovcnt", {16'd0, overrun_count}, {16'd0, ov0});
    enable = 1'b1;

    // pulse_cycles changed mid-DELAY: old width applies
    fire(24'd10, 24'd5, -1, 3, 24'd50, rk, wd, idr, vr, b0);
    check("cfg_rise", rk, 32'd10);
    check("cfg_width", wd, 32'd5);
    exp_id++;
    step();

    // backpressure: three events with ready low
    frame_ready = 1'b0;
    l0 = lost_total;
    for (int i = 0; i < 3; i++) begin
      fire(24'd1, 24'd2, -1, -1, 24'd0, rk, wd, idr, vr, b0);
      check($sformatf("bp%0d_id", i), idr, exp_id);
      exp_id++;
      repeat (4) step();
    end
    check("bp_valid_held", {31'd0, frame_valid}, 32'd1);
    check("bp_last_id", frame_id, exp_id - 1);
    check("bp_lost_count", lost_total - l0, 32'd2);
    frame_ready = 1'b1;
    step();
    check("bp_valid_clear", {31'd0, frame_valid}, 32'd0);

    // overrun_count saturation: trigger held high through a long pulse
    delay_cycles = 24'd0;
    pulse_cycles = 24'd66000;
    trigger_in = 1'b1;
    step();
    repeat (65600) step();
    trigger_in = 1'b0;
    check("sat_count", {16'd0, overrun_count}, 32'h0000_FFFF);
    wait_idle();
    check("sat_count_hold", {16'd0, overrun_count}, 32'h0000_FFFF);
    step();

    // asynchronous reset mid-pulse
    delay_cycles = 24'd0;
    pulse_cycles = 24'd50;
    trigger_in = 1'b1;
    step();
    trigger_in = 1'b0;
    repeat (3) step();
    check("ar_cam_before", {31'd0, cam_trigger}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_cam_async", {31'd0, cam_trigger}, 32'd0);
    check("ar_busy_async", {31'd0, busy}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("ar_cam", {31'd0, cam_trigger}, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_valid", {31'd0, frame_valid}, 32'd0);
    check("ar_id", frame_id, 32'd0);
    check("ar_ovcnt", {16'd0, overrun_count}, 32'd0);
    check("ar_overrun", {31'd0, overrun}, 32'd0);
    check("ar_lost", {31'd0, event_lost}, 32'd0);
    fire(24'd0, 24'd1, -1, -1, 24'd0, rk, wd, idr, vr, b0);
    check("ar_next_rise", rk, 32'd0);
    check("ar_next_width", wd, 32'd1);
    check("ar_next_id", idr, 32'd0);
    check("ar_next_valid", {31'd0, vr}, 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
